// File: rtl/bitstream_fetcher.sv
// Byte-fed, left-justified bit buffer serving variable-length reads to the
// arithmetic decoder, with sticky end-of-stream detection and zero padding.
module bitstream_fetcher #(
    parameter int BUF_W  = 32,
    parameter int MAX_RD = 16,
    parameter int LEN_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         request,
    input  logic [7:0]                   data,
    input  logic                         data_ready,
    input  logic                         rd_en,
    input  logic [LEN_W-1:0]             rd_len,
    output logic                         rd_ready,
    output logic                         rd_valid,
    output logic [MAX_RD-1:0]            rd_data,
    output logic                         rd_underrun,
    output logic [$clog2(BUF_W+1)-1:0]   bits_avail,
    output logic                         stream_end,
    output logic [31:0]                  bit_pos
);

    localparam int CW = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  bitBuf_q, bitBuf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              end_q;
    logic              rdValid_q;
    logic [MAX_RD-1:0] rdData_q, rdData_d;
    logic              rdUnder_q, rdUnder_d;
    logic [31:0]       bitPos_q, bitPos_d;

    logic [CW-1:0]     lenExt;
    logic [CW-1:0]     consumeLen;
    logic [CW-1:0]     takeLen;
    logic [CW-1:0]     cntAfter;
    logic [CW-1:0]     topAmt;
    logic [BUF_W-1:0]  bufShift;
    logic [BUF_W-1:0]  byteWide;
    logic              readAcc;
    logic              byteAcc;
    logic              endHit;

    // Consume first, then drop the incoming byte right behind the surviving bits;
    // the request threshold guarantees the byte always fits.
    always_comb begin
        lenExt     = CW'(rd_len);
        request    = !rst && !end_q && (cnt_q <= CW'(BUF_W - 8));
        rd_ready   = end_q || (cnt_q >= lenExt);
        readAcc    = rd_en && rd_ready;
        byteAcc    = request && data_ready;
        endHit     = request && !data_ready;

        consumeLen = readAcc ? lenExt : '0;
        takeLen    = (consumeLen > cnt_q) ? cnt_q : consumeLen;
        cntAfter   = cnt_q - takeLen;
        bufShift   = bitBuf_q << consumeLen;
        byteWide   = {data, {(BUF_W-8){1'b0}}} >> cntAfter;

        bitBuf_d   = byteAcc ? (bufShift | byteWide) : bufShift;
        cnt_d      = byteAcc ? (cntAfter + CW'(8)) : cntAfter;

        // Bits below the valid count are always zero, so underrun padding is free.
        topAmt     = CW'(BUF_W) - lenExt;
        rdData_d   = MAX_RD'(bitBuf_q >> topAmt);
        rdUnder_d  = lenExt > cnt_q;
        bitPos_d   = bitPos_q + 32'(consumeLen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitBuf_q  <= '0;
            cnt_q     <= '0;
            end_q     <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
            rdUnder_q <= 1'b0;
            bitPos_q  <= '0;
        end else begin
            bitBuf_q  <= bitBuf_d;
            cnt_q     <= cnt_d;
            if (endHit) begin
                end_q <= 1'b1;
            end
            rdValid_q <= readAcc;
            if (readAcc) begin
                rdData_q <= rdData_d;
            end
            rdUnder_q <= readAcc && rdUnder_d;
            bitPos_q  <= bitPos_d;
        end
    end

    assign rd_valid    = rdValid_q;
    assign rd_data     = rdData_q;
    assign rd_underrun = rdUnder_q;
    assign bits_avail  = cnt_q;
    assign stream_end  = end_q;
    assign bit_pos     = bitPos_q;

endmodule

// File: tb/tb_bitstream_fetcher.sv
// Directed and randomized bench for bitstream_fetcher, checked against a
// bit-queue model of the stream held in the bench.
module tb_bitstream_fetcher;

    localparam int BUF_W  = 32;
    localparam int MAX_RD = 16;
    localparam int LEN_W  = 5;
    localparam int CW     = $clog2(BUF_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              request;
    logic [7:0]        data;
    logic              data_ready;
    logic              rd_en = 1'b0;
    logic [LEN_W-1:0]  rd_len = '0;
    logic              rd_ready;
    logic              rd_valid;
    logic [MAX_RD-1:0] rd_data;
    logic              rd_underrun;
    logic [CW-1:0]     bits_avail;
    logic              stream_end;
    logic [31:0]       bit_pos;

    logic [7:0] srcMem [0:255];
    int         srcIdx = 0;
    int         srcLen = 0;

    bit         mBits [$];
    bit         mEnd;
    logic [31:0] mPos;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [15:0] lastData;
    logic        lastValid;
    logic        lastUnder;
    logic        lastAcc;
    logic        lastPreReady;

    bitstream_fetcher #(.BUF_W(BUF_W), .MAX_RD(MAX_RD), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .request    (request),
        .data       (data),
        .data_ready (data_ready),
        .rd_en      (rd_en),
        .rd_len     (rd_len),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_underrun(rd_underrun),
        .bits_avail (bits_avail),
        .stream_end (stream_end),
        .bit_pos    (bit_pos)
    );

    // The source presents its current byte until the fetcher takes it.
    assign data_ready = srcIdx < srcLen;
    assign data       = data_ready ? srcMem[srcIdx[7:0]] : 8'h00;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs before the edge,
    // advance source and model at the edge, then check registered outputs.
    task automatic applyStimulus(input logic en, input int len, input logic r);
        logic        mReq, mRdy, expValid, expUnder, dutReq, drNow;
        logic [7:0]  byteNow;
        logic [15:0] expData;
        int          n;
        rd_en  = en;
        rd_len = LEN_W'(len);
        rst    = r;
        #1;
        if (en) begin
            assertCount++;
            assert (len <= MAX_RD) else begin
                failCount++;
                $error("[TB] FAIL rd_len_legal observed=%0d expected<=%0d", len, MAX_RD);
            end
        end
        mReq = !r && !mEnd && (mBits.size() <= BUF_W - 8);
        mRdy = mEnd || (mBits.size() >= len);
        checkOutput("request", 64'(request), 64'(mReq));
        checkOutput("rd_ready", 64'(rd_ready), 64'(mRdy));
        lastPreReady = rd_ready;
        dutReq  = request;
        drNow   = data_ready;
        byteNow = data;
        @(posedge clk);
        #1;
        if (dutReq && drNow) srcIdx++;
        expValid = 1'b0;
        expUnder = 1'b0;
        expData  = '0;
        if (r) begin
            mBits.delete();
            mEnd = 1'b0;
            mPos = '0;
        end else begin
            if (en && mRdy) begin
                expValid = 1'b1;
                n = mBits.size();
                for (int i = 0; i < len; i++)
                    expData = {expData[14:0], (i < n) ? mBits[i] : 1'b0};
                expUnder = len > n;
                for (int i = 0; i < len && mBits.size() > 0; i++)
                    void'(mBits.pop_front());
                mPos = mPos + 32'(len);
            end
            if (mReq && drNow) begin
                for (int b = 7; b >= 0; b--) mBits.push_back(byteNow[b]);
            end else if (mReq && !drNow) begin
                mEnd = 1'b1;
            end
        end
        lastAcc = expValid;
        checkOutput("rd_valid", 64'(rd_valid), 64'(expValid));
        if (expValid) begin
            checkOutput("rd_data", 64'(rd_data), 64'(expData));
            checkOutput("rd_underrun", 64'(rd_underrun), 64'(expUnder));
        end
        checkOutput("bits_avail", 64'(bits_avail), 64'(mBits.size()));
        checkOutput("stream_end", 64'(stream_end), 64'(mEnd));
        checkOutput("bit_pos", 64'(bit_pos), 64'(mPos));
        lastData  = rd_data;
        lastValid = rd_valid;
        lastUnder = rd_underrun;
    endtask

    initial begin
        int          got;
        logic [7:0]  nextByte;
        logic        pending;
        logic        rEn;
        int          rLen;

        mEnd = 1'b0;
        mPos = '0;
        srcMem[0] = 8'hA5;
        srcMem[1] = 8'h3C;
        for (int i = 2; i < 256; i++) srcMem[i] = 8'(i * 7 + 1);
        srcLen = 200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("reset_avail", 64'(bits_avail), 64'h0);
        checkOutput("reset_pos", 64'(bit_pos), 64'h0);

        // Fill to full, then an 8-bit read returns the first byte
        for (int i = 0; i < 20 && mBits.size() < BUF_W; i++) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t1_full", 64'(bits_avail), 64'd32);
        applyStimulus(1'b1, 8, 1'b0);
        checkOutput("t1_data", 64'(lastData), 64'h00A5);
        checkOutput("t1_pos", 64'(bit_pos), 64'd8);
        checkOutput("t1_under", 64'(lastUnder), 64'h0);

        // Reads straddling byte boundaries on a fresh A5 3C stream
        srcIdx = 0;
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 4, 1'b0);
        checkOutput("t2_r4", 64'(lastData), 64'h000A);
        applyStimulus(1'b1, 9, 1'b0);
        checkOutput("t2_r9", 64'(lastData), 64'h00A7);
        applyStimulus(1'b1, 3, 1'b0);
        checkOutput("t2_r3", 64'(lastData), 64'h0004);

        // Sustained 16-bit reads over a 64-byte ramp
        for (int i = 0; i < 64; i++) srcMem[i] = 8'(i);
        srcIdx = 0;
        srcLen = 64;
        applyStimulus(1'b0, 0, 1'b1);
        got = 0;
        for (int c = 0; c < 300 && got < 32; c++) begin
            applyStimulus(1'b1, 16, 1'b0);
            if (lastValid) begin
                checkOutput("t3_word", 64'(lastData), 64'({8'(2 * got), 8'(2 * got + 1)}));
                got++;
            end
        end
        checkOutput("t3_count", 64'(got), 64'd32);

        // Short stream with underrun
        srcMem[0] = 8'hFF;
        srcMem[1] = 8'h00;
        srcMem[2] = 8'h81;
        srcIdx = 0;
        srcLen = 3;
        applyStimulus(1'b0, 0, 1'b1);
        for (int c = 0; c < 20 && !mEnd; c++) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t4_end", 64'(stream_end), 64'h1);
        applyStimulus(1'b1, 16, 1'b0);
        checkOutput("t4_w0", 64'(lastData), 64'hFF00);
        checkOutput("t4_u0", 64'(lastUnder), 64'h0);
        applyStimulus(1'b1, 16, 1'b0);
        checkOutput("t4_w1", 64'(lastData), 64'h8100);
        checkOutput("t4_u1", 64'(lastUnder), 64'h1);
        checkOutput("t4_avail", 64'(bits_avail), 64'h0);
        checkOutput("t4_req", 64'(request), 64'h0);
        applyStimulus(1'b1, 1, 1'b0);
        checkOutput("t4_w2", 64'(lastData), 64'h0000);
        checkOutput("t4_u2", 64'(lastUnder), 64'h1);

        // Reset colliding with an accepted read; source resumes where it was
        for (int i = 0; i < 256; i++) srcMem[i] = 8'($urandom);
        srcIdx = 0;
        srcLen = 200;
        applyStimulus(1'b0, 0, 1'b1);
        for (int i = 0; i < 20 && mBits.size() < BUF_W; i++) applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 12, 1'b0);
        checkOutput("t5_avail20", 64'(bits_avail), 64'd20);
        applyStimulus(1'b1, 8, 1'b1);
        checkOutput("t5_valid", 64'(lastValid), 64'h0);
        checkOutput("t5_avail", 64'(bits_avail), 64'h0);
        checkOutput("t5_req", 64'(request), 64'h0);
        nextByte = srcMem[srcIdx[7:0]];
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8, 1'b0);
        checkOutput("t5_resume", 64'(lastData), 64'(nextByte));

        // Zero-length read, then a read that must wait for fill
        for (int i = 0; i < 20 && mBits.size() < BUF_W; i++) applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("t6_z_valid", 64'(lastValid), 64'h1);
        checkOutput("t6_z_data", 64'(lastData), 64'h0);
        checkOutput("t6_z_avail", 64'(bits_avail), 64'd32);
        checkOutput("t6_z_pos", 64'(bit_pos), 64'd8);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        applyStimulus(1'b1, 12, 1'b0);
        checkOutput("t6_notready", 64'(lastPreReady), 64'h0);
        checkOutput("t6_wait", 64'(lastValid), 64'h0);
        applyStimulus(1'b1, 12, 1'b0);
        checkOutput("t6_acc", 64'(lastValid), 64'h1);

        // Randomized traffic over a random-length stream, with a mid-run reset
        srcLen = $urandom_range(30, 90);
        for (int i = 0; i < 256; i++) srcMem[i] = 8'($urandom);
        srcIdx = 0;
        srcLen = srcLen + 100;
        applyStimulus(1'b0, 0, 1'b1);
        srcIdx = 100;
        pending = 1'b0;
        rEn  = 1'b0;
        rLen = 0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                applyStimulus(1'b0, 0, 1'b1);
                pending = 1'b0;
            end
            if (!pending) begin
                rEn  = ($urandom_range(0, 3) != 0);
                rLen = $urandom_range(0, MAX_RD);
            end
            applyStimulus(rEn, rLen, 1'b0);
            pending = rEn && !lastAcc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bitstream_fetcher.md
Name: bitstream_fetcher

Overview:
- Consumer end of the byte-source handshake (`request`/`data`/`data_ready`) that feeds the VVC arithmetic decoder.
- Pulls bytes MSB-first into a bit buffer and serves variable-length reads of 0..MAX_RD bits to the decoding engine.
- Uses: init reads of 9 bits, renormalisation reads of 1..7 bits, bypass-bin reads.
- Detects end of stream and zero-pads reads past it, as CABAC requires.

Parameters:
- BUF_W, 32, bit-buffer width. Must be a multiple of 8 and >= MAX_RD+8.
- MAX_RD, 16, maximum bits per read.
- LEN_W, 5, rd_len width. Must be >= clog2(MAX_RD+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- request  out  1  byte request to source.
- data  in  8  byte from source; valid while data_ready=1.
- data_ready  in  1  1 = data holds a valid byte; 0 = stream exhausted (permanent).
- rd_en  in  1  read strobe.
- rd_len  in  LEN_W  number of bits to read, 0..MAX_RD; held stable while rd_en=1.
- rd_ready  out  1  read can be accepted this cycle.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  MAX_RD  read result, right-justified, first stream bit most significant.
- rd_underrun  out  1  with rd_valid: read crossed end of stream; missing bits returned as 0.
- bits_avail  out  clog2(BUF_W+1)  valid bits in buffer.
- stream_end  out  1  source reported exhaustion.
- bit_pos  out  32  total bits consumed since reset; wraps mod 2^32.

Behaviour:
- Buffer is left-justified. buf[BUF_W-1] is the next stream bit. Bits below bits_avail are 0.
- request = !rst && !stream_end && (bits_avail <= BUF_W-8). Combinational from registers and rst only; never from rd_en or data.
- Byte accept: a rising edge with request=1 and data_ready=1. data is captured at that edge, and the source advances at the same edge.
- End detection: a rising edge with request=1 and data_ready=0 sets stream_end, sticky until rst. request is then 0 forever.
- rd_ready = stream_end || (bits_avail >= rd_len). Combinational.
- Read accept: a rising edge with rd_en=1 and rd_ready=1. rd_en with rd_ready=0 is ignored; there is no queuing and the requester holds rd_en.
- Read latency: 1 cycle. From the accepting edge, rd_valid=1 for exactly one cycle with rd_data and rd_underrun. Back-to-back accepts give consecutive rd_valid pulses.
- rd_data = top rd_len bits of buf, zero-extended. rd_len=0 returns rd_valid=1, rd_data=0, no state change.
- Underrun: if accepted with rd_len > bits_avail (only possible when stream_end=1):
  - available bits are placed first, then zeros;
  - rd_underrun=1;
  - bits_avail becomes 0;
  - bit_pos still advances by rd_len.
- Same-edge consume + fill, in this order:
  1. Shift buf left by rd_len; cnt' = bits_avail - min(rd_len, bits_avail).
  2. Write the byte to buf[BUF_W-1-cnt' -: 8]; cnt' += 8.
  - The request condition guarantees cnt'+8 <= BUF_W.
- Widths: bits_avail never exceeds BUF_W. rd_len > MAX_RD is illegal; the verification bench flags it with an assertion, and RTL behaviour is undefined.
- Reset (synchronous, any cycle including mid-read):
  - buf=0, bits_avail=0, stream_end=0, rd_valid=0, rd_data=0, rd_underrun=0, bit_pos=0.
  - request=0 while rst=1.
  - A read accepted on the edge where rst=1 is discarded.
  - The source is not reset: bytes already accepted are lost, and fetching resumes with the source's next byte.
- Throughput: fill 8 bits/edge. Sustained 16-bit reads complete every 2 cycles; reads of 8 or fewer bits every cycle after warm-up.

Test Plan:
1. Reset, source bytes A5 3C …; wait for bits_avail=32; read 8 -> rd_valid next cycle, rd_data=0x00A5, bit_pos=8, rd_underrun=0.
2. Bytes A5 3C: read 4 -> 0x000A, then read 9 -> 0x00A7. Then read 3 -> 0x0004, covering reads that straddle byte boundaries.
3. rd_len=16 held with rd_en every cycle over a 64-byte ramp 00..3F -> rd_data=0x0001, 0x0203, … in order. No bytes lost. request deasserts whenever bits_avail > 24.
4. 3-byte stream FF 00 81: read 16 -> 0xFF00; read 16 -> 0x8100 with rd_underrun=1, bits_avail=0, stream_end=1, request=0. Next read 1 -> 0x0000 with rd_underrun=1.
5. rst asserted on the same edge as an accepted read with bits_avail=20 -> next cycle rd_valid=0, bits_avail=0, request=0. After release, request=1 and the next source byte is fetched.
6. rd_len=0 with rd_en -> rd_valid=1, rd_data=0, bits_avail and bit_pos unchanged. rd_len=12 with bits_avail=8 and no stream_end -> rd_ready=0 until fill, then accepted.
